// File: rtl/return_stack_if.sv
// Call/return stack port bundle: request side driven by control, status side by the stack.
interface return_stack_if #(
    parameter int CNTR_WIDTH = 8,
    parameter int PTR_WIDTH  = 3
);
    logic                  call;
    logic                  ret;
    logic                  clr_err;
    logic [CNTR_WIDTH-1:0] pc_in;
    logic [CNTR_WIDTH-1:0] ret_data;
    logic                  ret_f;
    logic [PTR_WIDTH:0]    count;
    logic                  empty;
    logic                  full;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output call, ret, clr_err, pc_in,
        input  ret_data, ret_f, count, empty, full, overflow, underflow
    );

    modport slave (
        input  call, ret, clr_err, pc_in,
        output ret_data, ret_f, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/return_stack.sv
// Fixed-depth hardware return-address LIFO with saturating count
// and sticky overflow/underflow flags.
module return_stack #(
    parameter int CNTR_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = 3
) (
    input logic           clk,
    input logic           rst,
    return_stack_if.slave bus
);
    localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH + 1)'(DEPTH);

    logic [CNTR_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH:0]    count;
    logic                  overflow;
    logic                  underflow;

    logic                  empty;
    logic                  full;
    logic [PTR_WIDTH-1:0]  ptr;
    logic [PTR_WIDTH-1:0]  top;
    logic                  do_write;
    logic [PTR_WIDTH-1:0]  wr_idx;
    logic                  inc;
    logic                  dec;
    logic                  set_ovf;
    logic                  set_unf;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign ptr   = count[PTR_WIDTH-1:0];
    assign top   = ptr - PTR_WIDTH'(1);

    // Call+ret on a non-empty stack overwrites the top in place, even when full.
    assign do_write = bus.call && (bus.ret ? 1'b1 : !full);
    assign wr_idx   = (bus.ret && !empty) ? top : ptr;

    assign inc     = bus.call && !full && (!bus.ret || empty);
    assign dec     = bus.ret && !bus.call && !empty;
    assign set_ovf = bus.call && !bus.ret && full;
    assign set_unf = bus.ret && empty;

    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            mem[wr_idx] <= bus.pc_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (inc) begin
                count <= count + 1'b1;
            end else if (dec) begin
                count <= count - 1'b1;
            end

            if (set_ovf) begin
                overflow <= 1'b1;
            end else if (bus.clr_err) begin
                overflow <= 1'b0;
            end

            if (set_unf) begin
                underflow <= 1'b1;
            end else if (bus.clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    assign bus.ret_data  = empty ? '0 : mem[top];
    assign bus.ret_f     = bus.ret && !empty;
    assign bus.count     = count;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;
endmodule

// File: tb/tb_return_stack.sv
// Randomized and directed bench for return_stack against a queue-based LIFO model.
module tb_return_stack;
    localparam int W = 8;
    localparam int DEPTH = 8;
    localparam int PW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    return_stack_if #(.CNTR_WIDTH(W), .PTR_WIDTH(PW)) bus ();

    return_stack #(.CNTR_WIDTH(W), .DEPTH(DEPTH), .PTR_WIDTH(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0] model [$];
    logic         m_ovf;
    logic         m_unf;
    logic [W-1:0] pre_data;
    logic         pre_f;
    logic [W-1:0] exp_pre_data;
    logic         exp_pre_f;

    function automatic logic [W-1:0] m_top();
        return (model.size() > 0) ? model[model.size()-1] : '0;
    endfunction

    task automatic idle_inputs();
        bus.call = 1'b0;
        bus.ret = 1'b0;
        bus.clr_err = 1'b0;
        bus.pc_in = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        model.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // One clock of stimulus; captures pre-edge outputs and advances the model.
    task automatic cycle(input logic c, input logic r, input logic clr, input logic [W-1:0] pc);
        logic so;
        logic su;
        @(negedge clk);
        bus.call = c;
        bus.ret = r;
        bus.clr_err = clr;
        bus.pc_in = pc;
        #1;
        pre_data = bus.ret_data;
        pre_f = bus.ret_f;
        exp_pre_data = m_top();
        exp_pre_f = r && (model.size() > 0);
        @(posedge clk);
        so = 1'b0;
        su = 1'b0;
        if (c && r) begin
            if (model.size() > 0) model[model.size()-1] = pc;
            else begin
                model.push_back(pc);
                su = 1'b1;
            end
        end else if (c) begin
            if (model.size() < DEPTH) model.push_back(pc);
            else so = 1'b1;
        end else if (r) begin
            if (model.size() > 0) void'(model.pop_back());
            else su = 1'b1;
        end
        m_ovf = so ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_unf = su ? 1'b1 : (clr ? 1'b0 : m_unf);
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
            errors++;
            $display("FAIL reset_status count=%0d empty=%b full=%b want 0/1/0",
                     bus.count, bus.empty, bus.full);
        end
        checks++;
        if (bus.ret_data !== 8'h00 || bus.ret_f !== 1'b0 ||
            bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs data=%h f=%b ovf=%b unf=%b want 00/0/0/0",
                     bus.ret_data, bus.ret_f, bus.overflow, bus.underflow);
        end
        cycle(1, 0, 0, 8'h11);
        cycle(1, 0, 0, 8'h22);
        cycle(1, 0, 0, 8'h33);
        @(negedge clk);
        #2;
        rst = 1'b1;
        bus.call = 1'b1;
        bus.pc_in = 8'hAA;
        #1;
        checks++;
        if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.ret_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset count=%0d empty=%b data=%h want 0/1/00",
                     bus.count, bus.empty, bus.ret_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.count !== 4'd0) begin
            errors++;
            $display("FAIL reset_edge_push count=%0d want 0", bus.count);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        model.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic test_lifo();
        logic [W-1:0] want [3];
        want[0] = 8'h30;
        want[1] = 8'h20;
        want[2] = 8'h10;
        do_reset();
        cycle(1, 0, 0, 8'h10);
        cycle(1, 0, 0, 8'h20);
        cycle(1, 0, 0, 8'h30);
        checks++;
        if (bus.count !== 4'd3 || bus.ret_data !== 8'h30) begin
            errors++;
            $display("FAIL lifo_push count=%0d data=%h want 3/30", bus.count, bus.ret_data);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 8'h00);
            checks++;
            if (pre_data !== want[i] || pre_f !== 1'b1) begin
                errors++;
                $display("FAIL lifo_pop%0d data=%h f=%b want %h/1", i, pre_data, pre_f, want[i]);
            end
        end
        checks++;
        if (bus.empty !== 1'b1 || bus.count !== 4'd0) begin
            errors++;
            $display("FAIL lifo_empty empty=%b count=%0d want 1/0", bus.empty, bus.count);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(1, 0, 0, 8'(8'hA0 + i));
            if (i == 7) begin
                checks++;
                if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_full full=%b ovf=%b want 1/0", bus.full, bus.overflow);
                end
            end
        end
        checks++;
        if (bus.overflow !== 1'b1 || bus.ret_data !== 8'hA7 || bus.count !== 4'd8) begin
            errors++;
            $display("FAIL ovf_drop ovf=%b data=%h count=%0d want 1/a7/8",
                     bus.overflow, bus.ret_data, bus.count);
        end
        cycle(0, 0, 1, 8'h00);
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear ovf=%b want 0", bus.overflow);
        end
        cycle(1, 0, 1, 8'hEE);
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins ovf=%b want 1", bus.overflow);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        cycle(0, 1, 0, 8'h00);
        checks++;
        if (pre_f !== 1'b0 || bus.count !== 4'd0 || bus.underflow !== 1'b1) begin
            errors++;
            $display("FAIL unf_pop f=%b count=%0d unf=%b want 0/0/1",
                     pre_f, bus.count, bus.underflow);
        end
        cycle(1, 0, 0, 8'h5A);
        cycle(0, 1, 0, 8'h00);
        checks++;
        if (pre_f !== 1'b1 || pre_data !== 8'h5A || bus.underflow !== 1'b1) begin
            errors++;
            $display("FAIL unf_sticky f=%b data=%h unf=%b want 1/5a/1",
                     pre_f, pre_data, bus.underflow);
        end
        cycle(1, 1, 0, 8'h77);
        checks++;
        if (pre_f !== 1'b0 || bus.count !== 4'd1 || bus.ret_data !== 8'h77) begin
            errors++;
            $display("FAIL unf_both_empty f=%b count=%0d data=%h want 0/1/77",
                     pre_f, bus.count, bus.ret_data);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        cycle(1, 0, 0, 8'h10);
        cycle(1, 0, 0, 8'h20);
        cycle(1, 1, 0, 8'h55);
        checks++;
        if (pre_f !== 1'b1 || pre_data !== 8'h20) begin
            errors++;
            $display("FAIL both_pre f=%b data=%h want 1/20", pre_f, pre_data);
        end
        checks++;
        if (bus.ret_data !== 8'h55 || bus.count !== 4'd2) begin
            errors++;
            $display("FAIL both_post data=%h count=%0d want 55/2", bus.ret_data, bus.count);
        end
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 8'(i));
        cycle(1, 1, 0, 8'h66);
        checks++;
        if (bus.overflow !== 1'b0 || bus.ret_data !== 8'h66 || bus.count !== 4'd8) begin
            errors++;
            $display("FAIL both_full ovf=%b data=%h count=%0d want 0/66/8",
                     bus.overflow, bus.ret_data, bus.count);
        end
    endtask

    task automatic test_integration();
        logic [W-1:0] pc;
        do_reset();
        pc = 8'h04;
        cycle(1, 0, 0, pc);
        pc = 8'h40;
        cycle(0, 0, 0, pc);
        pc = pc + 8'd1;
        cycle(0, 0, 0, pc);
        pc = pc + 8'd1;
        cycle(0, 1, 0, pc);
        if (pre_f) pc = pre_data + 8'd1;
        checks++;
        if (pc !== 8'h05 || pre_f !== 1'b1) begin
            errors++;
            $display("FAIL integ_ret pc=%h f=%b want 05/1", pc, pre_f);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic c;
            logic r;
            logic clr;
            c = ($urandom_range(99) < 50);
            r = ($urandom_range(99) < 45);
            clr = ($urandom_range(99) < 8);
            cycle(c, r, clr, 8'($urandom));
            checks++;
            if (pre_data !== exp_pre_data || pre_f !== exp_pre_f ||
                bus.count !== 4'(model.size()) || bus.ret_data !== m_top() ||
                bus.empty !== (model.size() == 0) || bus.full !== (model.size() == DEPTH) ||
                bus.overflow !== m_ovf || bus.underflow !== m_unf) begin
                errors++;
                if (bad < 10) begin
                    $display("FAIL rand%0d pre=%h/%b cnt=%0d top=%h flags=%b%b want %h/%b %0d %h %b%b",
                             n, pre_data, pre_f, bus.count, bus.ret_data, bus.overflow,
                             bus.underflow, exp_pre_data, exp_pre_f, model.size(), m_top(),
                             m_ovf, m_unf);
                end
                bad++;
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 8'(8'hC0 + i));
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 0, 8'h00);
            checks++;
            if (pre_data !== 8'(8'hC4 - i) || pre_f !== 1'b1) begin
                errors++;
                $display("FAIL b2b_pop%0d data=%h f=%b want %h/1", i, pre_data, pre_f, 8'(8'hC4 - i));
            end
        end
    endtask

    initial begin
        idle_inputs();
        model.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        test_reset();
        test_lifo();
        test_overflow();
        test_underflow();
        test_simultaneous();
        test_integration();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
